// File: rtl/decoder_stage_controller.sv
// Stage sequencer for the decoder array: load -> odd check -> (grow -> merge -> odd check)* -> result.
// Optional `DECODE_CYCLE_COUNTER_EN adds a 32-bit saturating busy-cycle counter output (cycle_count).
module decoder_stage_controller #(
  parameter int STAGE_WIDTH   = 3,
  parameter int PU_COUNT      = 8,
  parameter int LOAD_CYCLES   = 2,
  parameter int QUIET_CYCLES  = 3,
  parameter int MAX_ITERATION = 32,
  parameter int ITER_WIDTH    = $clog2(MAX_ITERATION + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   result_ack,
  input  logic [PU_COUNT-1:0]    pu_busy,
  input  logic [PU_COUNT-1:0]    pu_odd_cluster,
  output logic [STAGE_WIDTH-1:0] stage,
  output logic                   busy,
  output logic                   result_valid,
  output logic                   timeout,
  output logic [ITER_WIDTH-1:0]  iteration
`ifdef DECODE_CYCLE_COUNTER_EN
  ,
  output logic [31:0]            cycle_count
`endif
);

  localparam int LOAD_W  = $clog2(LOAD_CYCLES + 1);
  localparam int QUIET_W = $clog2(QUIET_CYCLES + 1);

  localparam logic [STAGE_WIDTH-1:0] S_IDLE   = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] S_LOAD   = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] S_GROW   = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] S_MERGE  = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] S_SYNC   = STAGE_WIDTH'(4);
  localparam logic [STAGE_WIDTH-1:0] S_RESULT = STAGE_WIDTH'(5);

  localparam logic [LOAD_W-1:0]     LOAD_LAST  = LOAD_W'(LOAD_CYCLES - 1);
  localparam logic [LOAD_W-1:0]     LOAD_MAX   = LOAD_W'(LOAD_CYCLES);
  localparam logic [QUIET_W-1:0]    QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);
  localparam logic [QUIET_W-1:0]    QUIET_MAX  = QUIET_W'(QUIET_CYCLES);
  localparam logic [ITER_WIDTH-1:0] ITER_MAX   = ITER_WIDTH'(MAX_ITERATION);

  logic [STAGE_WIDTH-1:0] state_q, state_d;
  logic [LOAD_W-1:0]      load_cnt_q, load_cnt_d;
  logic [QUIET_W-1:0]     quiet_cnt_q, quiet_cnt_d;
  logic [ITER_WIDTH-1:0]  iter_q, iter_d;
  logic                   timeout_q, timeout_d;

  logic                   any_busy;
  logic                   any_odd;
  logic                   quiet_done;
  logic [QUIET_W-1:0]     quiet_next;
  logic                   start_accept;

  assign any_busy     = |pu_busy;
  assign any_odd      = |pu_odd_cluster;
  assign start_accept = (state_q == S_IDLE) && start && !abort;

  // The current idle cycle completes the quiet window when QUIET_CYCLES-1 idle cycles precede it.
  assign quiet_done = !any_busy && (quiet_cnt_q == QUIET_LAST);

  always_comb begin
    quiet_next = quiet_cnt_q;
    if (any_busy) begin
      quiet_next = '0;
    end else if (quiet_cnt_q != QUIET_MAX) begin
      quiet_next = quiet_cnt_q + QUIET_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    iter_d      = iter_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          state_d    = S_LOAD;
          load_cnt_d = '0;
          iter_d     = '0;
          timeout_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_cnt_q >= LOAD_LAST) begin
          state_d = S_SYNC;
        end else if (load_cnt_q != LOAD_MAX) begin
          load_cnt_d = load_cnt_q + LOAD_W'(1);
        end
      end
      S_GROW: begin
        state_d = S_MERGE;
      end
      S_MERGE: begin
        if (quiet_done) begin
          state_d = S_SYNC;
        end else begin
          quiet_cnt_d = quiet_next;
        end
      end
      S_SYNC: begin
        if (quiet_done) begin
          if (!any_odd) begin
            state_d   = S_RESULT;
            timeout_d = 1'b0;
          end else if (iter_q < ITER_MAX) begin
            state_d = S_GROW;
            iter_d  = iter_q + ITER_WIDTH'(1);
          end else begin
            state_d   = S_RESULT;
            timeout_d = 1'b1;
          end
        end else begin
          quiet_cnt_d = quiet_next;
        end
      end
      S_RESULT: begin
        if (result_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, but the iteration count stays visible for debug.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      iter_d    = iter_q;
      timeout_d = 1'b0;
    end

    if (state_d != state_q) begin
      quiet_cnt_d = '0;
      load_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      quiet_cnt_q <= '0;
      iter_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      iter_q      <= iter_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stage        = state_q;
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_RESULT);
  assign timeout      = timeout_q;
  assign iteration    = iter_q;

`ifdef DECODE_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  // The acceptance cycle is the first decode cycle, so a fresh decode restarts the count at one.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (start_accept) begin
      cycle_cnt_d = 32'd1;
    end else if (busy && !result_valid && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cycle_count = cycle_cnt_q;
`endif

endmodule
